// File: rtl/serial_add_sub_ctrl.sv
// rtl/serial_add_sub_ctrl.sv - bit-serial add/subtract unit sharing one full adder across all bits
//
// Purpose:
//   Computes A+B (M=0) or A-B (M=1, two's complement) one bit per clock,
//   LSB first, using a single 1-bit full adder. A START/BUSY/DONE handshake
//   frames each operation. Results are held until the next one completes.
//
// Ports:
//   CLK     in   1      clock, rising-edge active
//   RST_N   in   1      asynchronous active-low reset
//   START   in   1      request, sampled only while idle
//   M       in   1      mode: 0 = add, 1 = subtract (sampled with START)
//   A       in   WIDTH  operand A (sampled with START)
//   B       in   WIDTH  operand B (sampled with START)
//   BUSY    out  1      high while bits are being processed
//   DONE    out  1      one-cycle pulse when RESULT/C_OUT/OVF are new
//   RESULT  out  WIDTH  sum or difference modulo 2^WIDTH
//   C_OUT   out  1      final carry; in subtract mode 1 means no borrow
//   OVF     out  1      signed overflow (carry into MSB xor carry out of MSB)

// 1-bit full adder: the only arithmetic element in the datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module serial_add_sub_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             M,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             C_OUT,
    output logic             OVF
);

    // Counter must hold 0..WIDTH-1; one extra bit keeps it safe at WIDTH=2^n.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    bit_cnt;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_next;

    full_adder u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Each new sum bit enters at the MSB and walks right; after WIDTH
    // shifts the first (bit-0) sum has reached position 0.
    assign res_next = {fa_sum, res_sr[WIDTH-1:1]};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            op_a    <= '0;
            op_b    <= '0;
            res_sr  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            RESULT  <= '0;
            C_OUT   <= 1'b0;
            OVF     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        // Subtract as A + ~B + 1: invert B and seed the carry with M.
                        op_a    <= A;
                        op_b    <= B ^ {WIDTH{M}};
                        carry   <= M;
                        bit_cnt <= '0;
                        BUSY    <= 1'b1;
                        state   <= S_RUN;
                    end
                end

                S_RUN: begin
                    op_a    <= op_a >> 1;
                    op_b    <= op_b >> 1;
                    res_sr  <= res_next;
                    carry   <= fa_cout;
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_cnt == LAST_BIT) begin
                        // MSB bit: carry is still the carry into the MSB here,
                        // fa_cout is the carry out of it.
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                        RESULT <= res_next;
                        C_OUT  <= fa_cout;
                        OVF    <= carry ^ fa_cout;
                        state  <= S_FIN;
                    end
                end

                S_FIN: begin
                    DONE  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
